// File: rtl/count_pkg.sv
// Shared types and defaults for the counter sequence monitor.
// Latency: n/a (declarations only). Backpressure: none.
package count_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        RESYNC  = 2'd3
    } mon_state_t;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_LOCK_CYCLES = 2;
    localparam int DEF_ERR_WIDTH   = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency: 1 cycle from inc to count. Backpressure: none.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_monitor_fsm.sv
// Tracks an external counter, locks after LOCK_CYCLES matches, flags sequence errors/wraps.
// Latency: all outputs registered, 1 cycle after the sample. Backpressure: none; COUNT_MONITOR_DOWN_EN adds CountDOWN.
module count_monitor_fsm
    import count_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter int ERR_WIDTH   = DEF_ERR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 CountUP,
`ifdef COUNT_MONITOR_DOWN_EN
    input  logic                 CountDOWN,
`endif
    input  logic [WIDTH-1:0]     CountValue,
    output logic                 Locked,
    output logic                 Mismatch,
    output logic                 WrapPulse,
    output logic [ERR_WIDTH-1:0] ErrorCount,
    output logic [WIDTH-1:0]     ExpectedValue
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    mon_state_t       state_q, state_d;
    logic [CNT_W-1:0] match_q, match_d, match_inc;
    logic [WIDTH-1:0] exp_d;
    logic             wrap_arm_q, wrap_arm_d;
    logic             locked_d, mismatch_d, wrap_d;
    logic             match;

    // Prediction for the next sample, and whether that step crosses all-ones -> zero upward.
    always_comb begin
        exp_d      = CountValue;
        wrap_arm_d = 1'b0;
`ifdef COUNT_MONITOR_DOWN_EN
        case ({CountUP, CountDOWN})
            2'b10: begin
                exp_d      = CountValue + WIDTH'(1);
                wrap_arm_d = &CountValue;
            end
            2'b01:   exp_d = CountValue - WIDTH'(1);
            default: exp_d = CountValue;
        endcase
`else
        exp_d      = CountValue + WIDTH'(CountUP);
        wrap_arm_d = CountUP & (&CountValue);
`endif
    end

    assign match     = (CountValue == ExpectedValue);
    assign match_inc = match_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        locked_d   = 1'b0;
        mismatch_d = 1'b0;
        wrap_d     = 1'b0;
        case (state_q)
            IDLE: begin
                match_d = '0;
                state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (match) begin
                    match_d = match_inc;
                    if (match_inc == CNT_W'(LOCK_CYCLES)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end else begin
                    match_d = '0;
                end
            end
            LOCKED: begin
                // A mismatch outranks a coincident wrap.
                if (match) begin
                    locked_d = 1'b1;
                    wrap_d   = wrap_arm_q;
                end else begin
                    mismatch_d = 1'b1;
                    state_d    = RESYNC;
                end
            end
            RESYNC: begin
                match_d = '0;
                state_d = ACQUIRE;
            end
            default: begin
                match_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            match_q       <= '0;
            wrap_arm_q    <= 1'b0;
            ExpectedValue <= '0;
            Locked        <= 1'b0;
            Mismatch      <= 1'b0;
            WrapPulse     <= 1'b0;
        end else begin
            state_q       <= state_d;
            match_q       <= match_d;
            wrap_arm_q    <= wrap_arm_d;
            ExpectedValue <= exp_d;
            Locked        <= locked_d;
            Mismatch      <= mismatch_d;
            WrapPulse     <= wrap_d;
        end
    end

    sat_counter #(
        .WIDTH (ERR_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (reset),
        .inc   (mismatch_d),
        .clear (1'b0),
        .count (ErrorCount)
    );

endmodule

// File: doc/count_monitor_fsm.md
COUNT_MONITOR_FSM -- requirements
Module: count_monitor_fsm

Interface
REQ-001 Parameter WIDTH, default 4, width of the observed count value.
REQ-002 Parameter LOCK_CYCLES, default 2, consecutive matching samples needed to declare lock.
REQ-003 Parameter ERR_WIDTH, default 8, width of the error counter.
REQ-004 Port clk  input  1  single clock; all sampling on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port CountUP  input  1  increment enable driven to the observed counter.
REQ-007 Port CountValue  input  WIDTH  count output of the observed counter.
REQ-008 Port Locked  output  1  high while the monitor tracks the counter without error.
REQ-009 Port Mismatch  output  1  one-cycle pulse per detected sequence error while locked.
REQ-010 Port WrapPulse  output  1  one-cycle pulse when a locked up-count wraps from all-ones to zero.
REQ-011 Port ErrorCount  output  ERR_WIDTH  saturating count of detected errors.
REQ-012 Port ExpectedValue  output  WIDTH  the monitor's predicted CountValue for the current sample.

Function
REQ-013 Every rising clk edge SHALL take one sample of (CountUP, CountValue); all outputs SHALL be registered.
REQ-014 Expected value for sample k SHALL be CountValue(k-1) + CountUP(k-1) modulo 2^WIDTH.
REQ-015 The FSM SHALL have the states IDLE, ACQUIRE, LOCKED and RESYNC.
REQ-016 IDLE: the first sample SHALL load the reference, clear the match count, and move to ACQUIRE.
REQ-017 ACQUIRE: a match SHALL increment the match count, and reaching LOCK_CYCLES SHALL move to LOCKED with Locked=1 from the next cycle.
REQ-018 ACQUIRE: a mismatch SHALL reload the reference and clear the match count, with no Mismatch pulse and no ErrorCount change.
REQ-019 LOCKED: a mismatch SHALL assert Mismatch for one cycle, increment ErrorCount, drop Locked, and move to RESYNC.
REQ-020 RESYNC SHALL last exactly one cycle, reload the reference from the current sample, and move to ACQUIRE.
REQ-021 ErrorCount SHALL saturate at 2^ERR_WIDTH-1 and never wrap.
REQ-022 WrapPulse SHALL fire only in LOCKED, on a matching sample where the previous value was all-ones and CountUP(k-1)=1.
REQ-023 If a hold (CountUP=0) is correctly tracked, the monitor SHALL produce no pulse.
REQ-024 If a mismatch and a wrap occur on the same sample, Mismatch SHALL take priority and WrapPulse SHALL stay low.

Reset
REQ-025 While reset=1, the block SHALL immediately, without a clock edge, force: state=IDLE, Locked=0, Mismatch=0, WrapPulse=0, ErrorCount=0, ExpectedValue=0, and match count=0.
REQ-026 Reset asserted mid-operation SHALL discard the lock and the error history.
REQ-027 The first sample after release SHALL be treated as an IDLE sample.

Configuration
REQ-028 Macro COUNT_MONITOR_DOWN_EN, when defined, SHALL add an input port CountDOWN (1 bit).
REQ-029 With COUNT_MONITOR_DOWN_EN defined, the expected value SHALL be prev-1 when only CountDOWN was high, and prev (hold) when both CountUP and CountDOWN were high.
REQ-030 With COUNT_MONITOR_DOWN_EN defined, a down-wrap from zero to all-ones SHALL be legal and SHALL NOT raise WrapPulse.
REQ-031 Without COUNT_MONITOR_DOWN_EN, the CountDOWN port SHALL be absent and decrement SHALL never be expected.

Structure
REQ-032 A shared package count_pkg SHALL hold the state enum (IDLE, ACQUIRE, LOCKED, RESYNC) and the default WIDTH, LOCK_CYCLES and ERR_WIDTH constants.
REQ-033 The saturating error counter SHALL be a sub-module sat_counter (parameter WIDTH, inputs inc and clear).

Verification
REQ-034 Release reset, then apply CountUP=1 from 0 for 20 cycles -> Locked=1 after the third post-reset edge, exactly one WrapPulse on the 15->0 sample, ErrorCount=0.
REQ-035 Apply CountUP=0 with CountValue held at 7 -> Locked=1, Mismatch never asserts.
REQ-036 While locked, force CountValue 5->9 with CountUP=1 -> Mismatch high one cycle, ErrorCount=1, Locked=0, relock three edges after RESYNC.
REQ-037 Inject 300 separate locked-state errors -> ErrorCount holds at 255.
REQ-038 Assert reset between clock edges while locked with ErrorCount=4 -> all outputs read 0 before the next edge.
REQ-039 With COUNT_MONITOR_DOWN_EN defined, drive CountDOWN=1 from 3 through 2, 1, 0, 15 -> no Mismatch, no WrapPulse, Locked stays high.
